// File: rtl/ring_endpoint.sv
// rtl/ring_endpoint.sv - ring endpoint with TX/RX packet queues and a TX offer/backoff FSM
package ring_endpoint_pkg;
    typedef struct packed {
        logic [7:0]   src;
        logic [7:0]   dest;
        logic [127:0] data;
    } pkt_t;
endpackage

module ring_endpoint
    import ring_endpoint_pkg::*;
#(
    parameter logic [7:0] NODE_ID = 8'd0,
    parameter int         QDEPTH  = 4,
    parameter int         BACKOFF = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         core_req_valid,
    output logic         core_req_ready,
    input  logic [7:0]   core_req_dest,
    input  logic [127:0] core_req_data,
    output pkt_t         ring_pkt_out,
    output logic         ring_pkt_valid,
    input  logic         ring_accept,
    input  logic         ring_full,
    input  pkt_t         ring_pkt_in,
    input  logic         ring_pkt_in_valid,
    output logic         core_rsp_valid,
    input  logic         core_rsp_ready,
    output logic [7:0]   core_rsp_src,
    output logic [127:0] core_rsp_data,
    output logic         rx_overflow,
    output logic         misroute,
    output logic [15:0]  tx_count,
    output logic [15:0]  rx_count,
    output logic [15:0]  drop_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (BACKOFF < 2) ? 1 : $clog2(BACKOFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BACKOFF} tx_state_e;

    tx_state_e         state_q, state_d;
    logic [BW-1:0]     bo_q, bo_d;

    pkt_t              tx_mem_q [QDEPTH];
    pkt_t              tx_mem_d [QDEPTH];
    logic [PW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;

    pkt_t              rx_mem_q [QDEPTH];
    pkt_t              rx_mem_d [QDEPTH];
    logic [PW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;

    logic [15:0]       tx_count_q, tx_count_d;
    logic [15:0]       rx_count_q, rx_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              misroute_q, misroute_d;

    logic              tx_enq, tx_deq;
    logic              rx_hit, rx_full, rx_enq, rx_deq, rx_drop;

    // TX queue: core enqueue at the tail, ring acceptance pops the head
    always_comb begin
        core_req_ready = (tx_cnt_q != CW'(QDEPTH));
        tx_enq         = core_req_valid && core_req_ready;
        // accept only counts while an offer is actually on the wire
        tx_deq         = (state_q == S_OFFER) && ring_accept;
        tx_mem_d       = tx_mem_q;
        tx_wr_d        = tx_wr_q;
        tx_rd_d        = tx_rd_q;
        if (tx_enq) begin
            tx_mem_d[tx_wr_q] = pkt_t'{src: NODE_ID, dest: core_req_dest, data: core_req_data};
            tx_wr_d           = tx_wr_q + PW'(1);
        end
        if (tx_deq) begin
            tx_rd_d = tx_rd_q + PW'(1);
        end
        tx_cnt_d       = tx_cnt_q + CW'(tx_enq) - CW'(tx_deq);
        ring_pkt_valid = (state_q == S_OFFER);
        ring_pkt_out   = ring_pkt_valid ? tx_mem_q[tx_rd_q] : '0;
    end

    // TX FSM: offer the head, back off for BACKOFF cycles when the ring is full
    always_comb begin
        state_d = state_q;
        bo_d    = bo_q;
        case (state_q)
            S_IDLE: begin
                if (tx_cnt_d != '0) state_d = S_OFFER;
            end
            S_OFFER: begin
                if (ring_accept) begin
                    state_d = (tx_cnt_d != '0) ? S_OFFER : S_IDLE;
                end else if (ring_full) begin
                    state_d = S_BACKOFF;
                    bo_d    = BW'(BACKOFF);
                end
            end
            S_BACKOFF: begin
                bo_d = bo_q - BW'(1);
                if (bo_q == BW'(1)) state_d = S_OFFER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RX queue: accept deliveries addressed here; a same-cycle pop frees a slot
    always_comb begin
        core_rsp_valid = (rx_cnt_q != '0);
        core_rsp_src   = rx_mem_q[rx_rd_q].src;
        core_rsp_data  = rx_mem_q[rx_rd_q].data;
        rx_deq         = core_rsp_valid && core_rsp_ready;
        rx_hit         = ring_pkt_in_valid && (ring_pkt_in.dest == NODE_ID);
        rx_full        = (rx_cnt_q == CW'(QDEPTH));
        rx_enq         = rx_hit && (!rx_full || rx_deq);
        rx_drop        = rx_hit && rx_full && !rx_deq;
        rx_mem_d       = rx_mem_q;
        rx_wr_d        = rx_wr_q;
        rx_rd_d        = rx_rd_q;
        if (rx_enq) begin
            rx_mem_d[rx_wr_q] = ring_pkt_in;
            rx_wr_d           = rx_wr_q + PW'(1);
        end
        if (rx_deq) begin
            rx_rd_d = rx_rd_q + PW'(1);
        end
        rx_cnt_d       = rx_cnt_q + CW'(rx_enq) - CW'(rx_deq);
    end

    // Event counters (free-running wrap) and sticky error flags
    always_comb begin
        tx_count_d    = tx_count_q + 16'(tx_deq);
        rx_count_d    = rx_count_q + 16'(rx_enq);
        drop_count_d  = drop_count_q + 16'(rx_drop);
        rx_overflow_d = rx_overflow_q || rx_drop;
        misroute_d    = misroute_q || (ring_pkt_in_valid && (ring_pkt_in.dest != NODE_ID));
        tx_count      = tx_count_q;
        rx_count      = rx_count_q;
        drop_count    = drop_count_q;
        rx_overflow   = rx_overflow_q;
        misroute      = misroute_q;
    end

    // Queue storage; contents are don't-care while the matching count is zero
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bo_q          <= '0;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_cnt_q      <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_cnt_q      <= '0;
            tx_count_q    <= '0;
            rx_count_q    <= '0;
            drop_count_q  <= '0;
            rx_overflow_q <= 1'b0;
            misroute_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bo_q          <= bo_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_count_q    <= tx_count_d;
            rx_count_q    <= rx_count_d;
            drop_count_q  <= drop_count_d;
            rx_overflow_q <= rx_overflow_d;
            misroute_q    <= misroute_d;
        end
    end

endmodule

// File: tb/tb_ring_endpoint.sv
// tb/tb_ring_endpoint.sv - self-checking bench for ring_endpoint against a queue-based model
module tb_ring_endpoint;
    import ring_endpoint_pkg::*;

    localparam logic [7:0] NODE = 8'd1;
    localparam int         QD   = 4;
    localparam int         BO   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_req_valid;
    logic         core_req_ready;
    logic [7:0]   core_req_dest;
    logic [127:0] core_req_data;
    pkt_t         ring_pkt_out;
    logic         ring_pkt_valid;
    logic         ring_accept;
    logic         ring_full;
    pkt_t         ring_pkt_in;
    logic         ring_pkt_in_valid;
    logic         core_rsp_valid;
    logic         core_rsp_ready;
    logic [7:0]   core_rsp_src;
    logic [127:0] core_rsp_data;
    logic         rx_overflow;
    logic         misroute;
    logic [15:0]  tx_count;
    logic [15:0]  rx_count;
    logic [15:0]  drop_count;

    always #5 clk = ~clk;

    ring_endpoint #(.NODE_ID(NODE), .QDEPTH(QD), .BACKOFF(BO)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_dest(core_req_dest), .core_req_data(core_req_data),
        .ring_pkt_out(ring_pkt_out), .ring_pkt_valid(ring_pkt_valid),
        .ring_accept(ring_accept), .ring_full(ring_full),
        .ring_pkt_in(ring_pkt_in), .ring_pkt_in_valid(ring_pkt_in_valid),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_src(core_rsp_src), .core_rsp_data(core_rsp_data),
        .rx_overflow(rx_overflow), .misroute(misroute),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
    );

    // Reference model: packet queues plus a notion of "offering" / "waiting N more cycles"
    pkt_t        m_txq[$];
    pkt_t        m_rxq[$];
    int          m_mode;       // 0 = not offering, 1 = offering head, 2 = suppressed
    int          m_left;
    logic [15:0] m_txc, m_rxc, m_drc;
    bit          m_ovf, m_mis;
    bit          m_ok = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    bit          last_valid;
    pkt_t        last_pkt;

    task automatic check(input string tag, input logic [143:0] act, input logic [143:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        pkt_t ep;
        if (!m_ok) return;
        ep = '0;
        if (m_mode == 1) ep = m_txq[0];
        check("core_req_ready", core_req_ready, m_txq.size() < QD);
        check("ring_pkt_valid", ring_pkt_valid, m_mode == 1);
        check("ring_pkt_out", ring_pkt_out, ep);
        check("core_rsp_valid", core_rsp_valid, m_rxq.size() > 0);
        if (m_rxq.size() > 0) begin
            check("core_rsp_src", core_rsp_src, m_rxq[0].src);
            check("core_rsp_data", core_rsp_data, m_rxq[0].data);
        end
        check("rx_overflow", rx_overflow, m_ovf);
        check("misroute", misroute, m_mis);
        check("tx_count", tx_count, m_txc);
        check("rx_count", rx_count, m_rxc);
        check("drop_count", drop_count, m_drc);
    endtask

    task automatic model_update();
        bit enq, deq, rdeq;
        int pre_rx;
        if (reset) begin
            m_txq.delete(); m_rxq.delete();
            m_mode = 0; m_left = 0;
            m_txc = '0; m_rxc = '0; m_drc = '0;
            m_ovf = 1'b0; m_mis = 1'b0;
            m_ok = 1'b1;
            return;
        end
        if (!m_ok) return;
        enq    = core_req_valid && (m_txq.size() < QD);
        deq    = (m_mode == 1) && ring_accept;
        rdeq   = (m_rxq.size() > 0) && core_rsp_ready;
        pre_rx = m_rxq.size();
        if (deq) begin
            void'(m_txq.pop_front());
            m_txc++;
        end
        if (enq) m_txq.push_back(pkt_t'{src: NODE, dest: core_req_dest, data: core_req_data});
        case (m_mode)
            0: if (m_txq.size() > 0) m_mode = 1;
            1: begin
                if (deq) m_mode = (m_txq.size() > 0) ? 1 : 0;
                else if (ring_full) begin m_mode = 2; m_left = BO; end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = 1;
            end
        endcase
        if (rdeq) void'(m_rxq.pop_front());
        if (ring_pkt_in_valid) begin
            if (ring_pkt_in.dest != NODE) m_mis = 1'b1;
            else if (pre_rx < QD || rdeq) begin m_rxq.push_back(ring_pkt_in); m_rxc++; end
            else begin m_ovf = 1'b1; m_drc++; end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        last_valid = ring_pkt_valid;
        last_pkt   = ring_pkt_out;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        core_req_valid = 0; core_req_dest = '0; core_req_data = '0;
        ring_accept = 0; ring_full = 0; ring_pkt_in = '0; ring_pkt_in_valid = 0;
        core_rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1; cycle(); reset = 0;
    endtask

    initial begin
        pkt_t exp_pkt;
        int   low;
        reset = 1; idle_in();
        cycle(); cycle();
        reset = 0;

        // single request, ring always accepting
        do_reset();
        core_req_valid = 1; core_req_dest = 8'd2; core_req_data = 128'h1234; ring_accept = 1;
        cycle();
        core_req_valid = 0;
        cycle();
        exp_pkt = '{src: 8'd1, dest: 8'd2, data: 128'h1234};
        check("t41_valid_next_cycle", last_valid, 1'b1);
        check("t41_pkt", last_pkt, exp_pkt);
        check("t41_tx_count", tx_count, 16'd1);
        cycle();

        // fill the TX queue with the ring refusing; 5th request stalls
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_req_valid = 1; core_req_dest = 8'd3; core_req_data = 128'(i + 100);
            cycle();
        end
        check("t42_ready_low", core_req_ready, 1'b0);
        core_req_data = 128'd999;
        repeat (3) cycle();
        exp_pkt = '{src: 8'd1, dest: 8'd3, data: 128'd100};
        check("t42_head_stable", last_pkt, exp_pkt);
        core_req_valid = 0; ring_accept = 1;
        repeat (4) cycle();
        check("t42_tx_count", tx_count, 16'd4);
        check("t42_drained", core_req_ready, 1'b1);
        ring_accept = 0;

        // backoff suppresses the offer for exactly BO cycles
        do_reset();
        core_req_valid = 1; core_req_dest = 8'd5; core_req_data = 128'hABCD;
        cycle();
        core_req_valid = 0; ring_full = 1;
        cycle();
        check("t43_offer", last_valid, 1'b1);
        ring_full = 0;
        low = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_valid) break;
            low++;
        end
        exp_pkt = '{src: 8'd1, dest: 8'd5, data: 128'hABCD};
        check("t43_low_cycles", low, 3);
        check("t43_reoffer", last_pkt, exp_pkt);
        ring_accept = 1; cycle(); ring_accept = 0;

        // RX overflow with the core not draining
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ring_pkt_in_valid = 1; ring_pkt_in = '{src: 8'd7, dest: NODE, data: 128'(i)};
            cycle();
        end
        ring_pkt_in_valid = 0;
        cycle();
        check("t44_rx_count", rx_count, 16'd4);
        check("t44_drop_count", drop_count, 16'd1);
        check("t44_overflow", rx_overflow, 1'b1);

        // full RX queue: simultaneous pop and delivery is accepted, order kept
        core_rsp_ready = 1; ring_pkt_in_valid = 1;
        ring_pkt_in = '{src: 8'd9, dest: NODE, data: 128'h55};
        cycle();
        ring_pkt_in_valid = 0; core_rsp_ready = 0;
        check("t46_no_drop", drop_count, 16'd1);
        check("t46_rx_count", rx_count, 16'd5);
        check("t46_head", core_rsp_data, 128'd1);
        core_rsp_ready = 1;
        repeat (4) cycle();
        check("t46_empty", core_rsp_valid, 1'b0);
        core_rsp_ready = 0;

        // reset in the middle of an offer
        core_req_valid = 1; core_req_dest = 8'd4; core_req_data = 128'h77;
        cycle();
        core_req_valid = 0;
        cycle();
        check("t46_offering", ring_pkt_valid, 1'b1);
        reset = 1; cycle(); reset = 0;
        check("t46_rst_valid", ring_pkt_valid, 1'b0);
        check("t46_rst_out", ring_pkt_out, 144'd0);
        check("t46_rst_ready", core_req_ready, 1'b1);
        check("t46_rst_flags", {rx_overflow, misroute}, 2'b00);
        cycle();
        check("t46_abandoned", ring_pkt_valid, 1'b0);

        // misrouted delivery
        do_reset();
        ring_pkt_in_valid = 1; ring_pkt_in = '{src: 8'd3, dest: NODE + 8'd1, data: 128'h9};
        cycle();
        ring_pkt_in_valid = 0;
        check("t45_misroute", misroute, 1'b1);
        check("t45_rsp_valid", core_rsp_valid, 1'b0);
        check("t45_rx_count", rx_count, 16'd0);
        cycle();

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset             = ($urandom_range(0, 199) == 0);
            core_req_valid    = $urandom_range(0, 1);
            core_req_dest     = 8'($urandom);
            core_req_data     = {$urandom, $urandom, $urandom, $urandom};
            ring_accept       = ($urandom_range(0, 1) == 0);
            ring_full         = ($urandom_range(0, 9) < 3);
            ring_pkt_in_valid = ($urandom_range(0, 9) < 4);
            ring_pkt_in.src   = 8'($urandom);
            ring_pkt_in.dest  = ($urandom_range(0, 7) == 0) ? 8'd2 : NODE;
            ring_pkt_in.data  = {$urandom, $urandom, $urandom, $urandom};
            core_rsp_ready    = ($urandom_range(0, 2) != 0);
            cycle();
        end
        reset = 0; idle_in();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
